// File: rtl/data_memory_bytewise_if.sv
// Request/response bundle between the MEM stage (master) and the
// byte-addressable data memory (slave).
//   req, wr_en, size, sign_ext, addr, data_in : request from the MEM stage
//   ready, data_out, rd_valid, misaligned     : status/response from memory
interface data_memory_bytewise_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int BUS_WIDTH  = 32
);
  logic                  req;
  logic                  wr_en;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BUS_WIDTH-1:0]  data_in;
  logic                  ready;
  logic [BUS_WIDTH-1:0]  data_out;
  logic                  rd_valid;
  logic                  misaligned;

  modport master (
    output req, wr_en, size, sign_ext, addr, data_in,
    input  ready, data_out, rd_valid, misaligned
  );

  modport slave (
    input  req, wr_en, size, sign_ext, addr, data_in,
    output ready, data_out, rd_valid, misaligned
  );
endinterface

// File: rtl/data_memory_bytewise.sv
// Byte/half/word/doubleword data memory with little-endian lane selection,
// signed/unsigned load extension, misalignment detection and an optional
// zero-fill sequence after reset.
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : slave side of data_memory_bytewise_if (request in, load data,
//           rd_valid / misaligned pulses and ready out)
// Loads are two-stage: the word is read at the acceptance edge, extended
// and presented on data_out one edge later.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_INIT | zero-fill one word per cycle, requests ignored
// ST_RUN  | ready, one access per cycle
module data_memory_bytewise #(
  parameter int CAPACITY       = 512,
  parameter int BUS_WIDTH      = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  data_memory_bytewise_if.slave  bus
);
  localparam int NBYTES     = BUS_WIDTH / 8;
  localparam int LANE_W     = $clog2(NBYTES);
  localparam int ADDR_WIDTH = $clog2(CAPACITY * NBYTES);
  localparam int IDX_W      = ADDR_WIDTH - LANE_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_e               state_q;
  logic [IDX_W-1:0]     clr_cnt_q;
  logic                 ready_q;
  logic [BUS_WIDTH-1:0] data_out_q;
  logic                 rd_valid_q;
  logic                 misaligned_q;
  logic                 ld_pend_q;
  logic                 mis_pend_q;
  logic [LANE_W-1:0]    lane_q;
  logic [1:0]           size_q;
  logic                 sext_q;
  logic [BUS_WIDTH-1:0] rd_word_q;
  logic [BUS_WIDTH-1:0] mem_q [CAPACITY];

  logic                 accept;
  logic                 legal;
  logic [IDX_W-1:0]     idx;
  logic [LANE_W-1:0]    lane;
  logic [NBYTES-1:0]    be_base;
  logic [NBYTES-1:0]    be;
  logic [BUS_WIDTH-1:0] wdata_sh;
  logic [BUS_WIDTH-1:0] rd_sh;
  logic [BUS_WIDTH-1:0] fmask;
  logic                 sbit;
  logic [BUS_WIDTH-1:0] load_val;
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_idx;
  logic [NBYTES-1:0]    mem_be;
  logic [BUS_WIDTH-1:0] mem_wdata;

  // ready_q is only ever set in ST_RUN, so it also gates out INIT cycles
  assign accept   = bus.req && ready_q;
  assign idx      = bus.addr[ADDR_WIDTH-1:LANE_W];
  assign lane     = bus.addr[LANE_W-1:0];
  assign be       = be_base << lane;
  assign wdata_sh = bus.data_in << {lane, 3'b000};

  always_comb begin
    legal   = 1'b0;
    be_base = '1;
    case (bus.size)
      2'd0: begin legal = 1'b1;                    be_base = NBYTES'(1);  end
      2'd1: begin legal = ~bus.addr[0];            be_base = NBYTES'(3);  end
      2'd2: begin legal = (bus.addr[1:0] == 2'b0); be_base = NBYTES'(15); end
      default: begin
        legal   = (BUS_WIDTH == 64) && (bus.addr[2:0] == 3'b0);
        be_base = '1;
      end
    endcase
  end

  // load extraction works on the word captured at acceptance
  assign rd_sh = rd_word_q >> {lane_q, 3'b000};

  always_comb begin
    fmask = '1;
    sbit  = rd_sh[BUS_WIDTH-1];
    case (size_q)
      2'd0:    begin fmask = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - 8);  sbit = rd_sh[7];  end
      2'd1:    begin fmask = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - 16); sbit = rd_sh[15]; end
      2'd2:    begin fmask = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - 32); sbit = rd_sh[31]; end
      default: begin fmask = '1;                                    sbit = rd_sh[BUS_WIDTH-1]; end
    endcase
    load_val = (rd_sh & fmask) | ((sext_q && sbit) ? ~fmask : '0);
  end

  // one write port shared between the zero-fill sweep and stores
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_be    = be;
    mem_wdata = wdata_sh;
    if (!rst_i && state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_idx   = clr_cnt_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (!rst_i && accept && legal && bus.wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (accept) rd_word_q <= mem_q[idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RST_STATE;
      clr_cnt_q    <= '0;
      ready_q      <= 1'b0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      ld_pend_q    <= 1'b0;
      mis_pend_q   <= 1'b0;
    end else begin
      ld_pend_q    <= accept && legal && !bus.wr_en;
      mis_pend_q   <= accept && !legal;
      rd_valid_q   <= ld_pend_q;
      misaligned_q <= mis_pend_q;
      if (ld_pend_q) data_out_q <= load_val;
      if (accept) begin
        lane_q <= lane;
        size_q <= bus.size;
        sext_q <= bus.sign_ext;
      end
      case (state_q)
        ST_INIT: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == IDX_W'(CAPACITY - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN:  ready_q <= 1'b1;
        default: state_q <= RST_STATE;
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.data_out   = data_out_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.misaligned = misaligned_q;
endmodule

// File: tb/tb_data_memory_bytewise.sv
module tb_data_memory_bytewise;
  logic clk = 1'b0;
  logic rst, rst64;
  always #5 clk = ~clk;

  data_memory_bytewise_if #(.ADDR_WIDTH(11), .BUS_WIDTH(32)) bus32 ();
  data_memory_bytewise_if #(.ADDR_WIDTH(7),  .BUS_WIDTH(64)) bus64 ();

  data_memory_bytewise #(.CAPACITY(512), .BUS_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut32 (
    .clk_i(clk), .rst_i(rst), .bus(bus32));
  data_memory_bytewise #(.CAPACITY(16), .BUS_WIDTH(64), .CLEAR_ON_RESET(1'b0)) dut64 (
    .clk_i(clk), .rst_i(rst64), .bus(bus64));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [10:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ev;
    logic        em;
  } vec_t;
  vec_t vecs[$];

  // byte-addressed reference image of the 32-bit memory
  logic [7:0]  ref_mem [2048];
  logic [31:0] m_data;
  logic        m_valid, m_mis;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sx,
                              input logic [10:0] a, input logic [31:0] d,
                              input logic [31:0] ed, input logic ev, input logic em);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sx = sx; v.a = a; v.d = d; v.ed = ed; v.ev = ev; v.em = em;
    return v;
  endfunction

  task automatic model(input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [10:0] a, input logic [31:0] d);
    int n = 1 << sz;
    bit ok = (sz != 2'd3) && ((int'(a) % n) == 0);
    longint unsigned v = 0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    if (!ok) m_mis = 1'b1;
    else if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) v |= longint'(ref_mem[int'(a) + i]) << (8 * i);
      if (sx && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
      m_data  = v[31:0];
      m_valid = 1'b1;
    end
  endtask

  task automatic drive32(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [10:0] a, input logic [31:0] d);
    bus32.req = 1'b1; bus32.wr_en = wr; bus32.size = sz; bus32.sign_ext = sx;
    bus32.addr = a; bus32.data_in = d;
  endtask

  task automatic acc32(input string nm, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [10:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ev, input logic em);
    drive32(wr, sz, sx, a, d);
    step();
    bus32.req = 1'b0;
    step();
    chk({nm, " rd_valid"},   64'(bus32.rd_valid),   64'(ev));
    chk({nm, " misaligned"}, 64'(bus32.misaligned), 64'(em));
    chk({nm, " data_out"},   64'(bus32.data_out),   64'(ed));
    step();
    chk({nm, " pulse_end"}, 64'({bus32.rd_valid, bus32.misaligned}), 64'd0);
  endtask

  task automatic acc64(input string nm, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [6:0] a, input logic [63:0] d,
                       input logic [63:0] ed, input logic ev, input logic em);
    bus64.req = 1'b1; bus64.wr_en = wr; bus64.size = sz; bus64.sign_ext = sx;
    bus64.addr = a; bus64.data_in = d;
    step();
    bus64.req = 1'b0;
    step();
    chk({nm, " rd_valid"},   64'(bus64.rd_valid),   64'(ev));
    chk({nm, " misaligned"}, 64'(bus64.misaligned), 64'(em));
    chk({nm, " data_out"},   bus64.data_out,        ed);
    step();
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (bus32.ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic wr, sx;
    logic [1:0] sz;
    logic [10:0] a;
    logic [31:0] d;

    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    m_data = '0;
    rst = 1'b1; rst64 = 1'b1;
    drive32(1'b0, 2'd0, 1'b0, '0, '0); bus32.req = 1'b0;
    bus64.req = 1'b0; bus64.wr_en = 1'b0; bus64.size = 2'd0; bus64.sign_ext = 1'b0;
    bus64.addr = '0; bus64.data_in = '0;
    step(); step();

    chk("reset ready",      64'(bus32.ready),      64'd0);
    chk("reset data_out",   64'(bus32.data_out),   64'd0);
    chk("reset rd_valid",   64'(bus32.rd_valid),   64'd0);
    chk("reset misaligned", 64'(bus32.misaligned), 64'd0);
    chk("reset64 ready",    64'(bus64.ready),      64'd0);

    // 64-bit instance, no clearing: ready on the first edge out of reset
    rst64 = 1'b0;
    step();
    chk("ready64 first edge", 64'(bus64.ready), 64'd1);
    acc64("st dword 0x08", 1, 2'd3, 0, 7'h08, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0);
    acc64("ld word 0x0C",  0, 2'd2, 0, 7'h0C, 64'h0, 64'h0000_0000_0123_4567, 1, 0);
    acc64("ld dword 0x08", 0, 2'd3, 0, 7'h08, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0);
    acc64("ld half 0x0A s",0, 2'd1, 1, 7'h0A, 64'h0, 64'hFFFF_FFFF_FFFF_89AB, 1, 0);
    acc64("ld byte 0x0F s",0, 2'd0, 1, 7'h0F, 64'h0, 64'h0000_0000_0000_0001, 1, 0);
    acc64("ld word 0x08 s",0, 2'd2, 1, 7'h08, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1, 0);
    acc64("ld dword 0x04", 0, 2'd3, 0, 7'h04, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 0, 1);

    // 32-bit instance zero-fill
    rst = 1'b0;
    count_init(n);
    chk("init cycles", 64'(n), 64'd512);

    vecs.push_back(mk(1, 2'd2, 0, 11'h010, 32'h8000_7F80, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 11'h010, 32'h0, 32'hFFFF_FF80, 1, 0));
    vecs.push_back(mk(0, 2'd0, 1, 11'h011, 32'h0, 32'h0000_007F, 1, 0));
    vecs.push_back(mk(0, 2'd0, 1, 11'h012, 32'h0, 32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 2'd0, 1, 11'h013, 32'h0, 32'hFFFF_FF80, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 11'h010, 32'h0, 32'h0000_0080, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 11'h011, 32'h0, 32'h0000_007F, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 11'h012, 32'h0, 32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 11'h013, 32'h0, 32'h0000_0080, 1, 0));
    vecs.push_back(mk(1, 2'd2, 0, 11'h020, 32'h1122_3344, 32'h0000_0080, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 11'h021, 32'hFFFF_FFAB, 32'h0000_0080, 0, 0));
    vecs.push_back(mk(0, 2'd2, 0, 11'h020, 32'h0, 32'h1122_AB44, 1, 0));
    vecs.push_back(mk(0, 2'd1, 0, 11'h022, 32'h0, 32'h0000_1122, 1, 0));
    vecs.push_back(mk(0, 2'd1, 0, 11'h003, 32'h0, 32'h0000_1122, 0, 1));
    vecs.push_back(mk(1, 2'd2, 0, 11'h006, 32'hDEAD_BEEF, 32'h0000_1122, 0, 1));
    vecs.push_back(mk(0, 2'd3, 0, 11'h008, 32'h0, 32'h0000_1122, 0, 1));
    vecs.push_back(mk(1, 2'd3, 0, 11'h000, 32'hFFFF_FFFF, 32'h0000_1122, 0, 1));
    vecs.push_back(mk(0, 2'd2, 0, 11'h004, 32'h0, 32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 2'd1, 1, 11'h020, 32'h0, 32'hFFFF_AB44, 1, 0));
    vecs.push_back(mk(0, 2'd2, 0, 11'h000, 32'h0, 32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 2'd1, 0, 11'h020, 32'h0, 32'h0000_AB44, 1, 0));
    vecs.push_back(mk(0, 2'd2, 1, 11'h7FC, 32'h0, 32'h0000_0000, 1, 0));

    foreach (vecs[i]) begin
      model(vecs[i].wr, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].d);
      acc32($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].sx, vecs[i].a,
            vecs[i].d, vecs[i].ed, vecs[i].ev, vecs[i].em);
    end

    for (int k = 0; k < 300; k++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = 11'($urandom_range(0, 127));
      d  = $urandom;
      model(wr, sz, sx, a, d);
      acc32($sformatf("rnd%0d", k), wr, sz, sx, a, d, m_data, m_valid, m_mis);
    end

    // store, then back-to-back loads to the same word
    drive32(1, 2'd2, 0, 11'h040, 32'h5A5A_1234); step();
    drive32(0, 2'd2, 0, 11'h040, 32'h0);         step();
    chk("b2b after store rd_valid", 64'(bus32.rd_valid), 64'd0);
    drive32(0, 2'd1, 1, 11'h042, 32'h0);         step();
    bus32.req = 1'b0;
    chk("b2b load1 rd_valid", 64'(bus32.rd_valid), 64'd1);
    chk("b2b load1 data",     64'(bus32.data_out), 64'h5A5A_1234);
    step();
    chk("b2b load2 rd_valid", 64'(bus32.rd_valid), 64'd1);
    chk("b2b load2 data",     64'(bus32.data_out), 64'h0000_5A5A);
    step();
    chk("b2b end rd_valid",   64'(bus32.rd_valid), 64'd0);

    // reset right after a load is accepted cancels its pulse
    drive32(1, 2'd2, 0, 11'h030, 32'hCAFE_BABE); step();
    drive32(0, 2'd2, 0, 11'h030, 32'h0);         step();
    bus32.req = 1'b0; rst = 1'b1;
    step();
    chk("rst cancel rd_valid", 64'(bus32.rd_valid),   64'd0);
    chk("rst cancel data",     64'(bus32.data_out),   64'd0);
    chk("rst cancel ready",    64'(bus32.ready),      64'd0);
    chk("rst cancel misalign", 64'(bus32.misaligned), 64'd0);
    rst = 1'b0;
    count_init(n);
    chk("reinit cycles", 64'(n), 64'd512);

    // reset in the middle of INIT restarts the sweep
    rst = 1'b1; step(); rst = 1'b0;
    repeat (100) step();
    chk("mid-init ready", 64'(bus32.ready), 64'd0);
    rst = 1'b1; step(); rst = 1'b0;
    count_init(n);
    chk("restart init cycles", 64'(n), 64'd512);

    acc32("cleared 0x30", 0, 2'd2, 0, 11'h030, 32'h0, 32'h0, 1, 0);
    acc32("cleared 0x40", 0, 2'd2, 0, 11'h040, 32'h0, 32'h0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
